// File: rtl/uart_rx_frame_ctrl_pkg.sv
// rtl/uart_rx_frame_ctrl_pkg.sv - frame constants and FSM state type for the UART receiver
package uart_rx_frame_ctrl_pkg;

  localparam int BAUD_START    = 1;
  localparam int BAUD_DATA     = 8;
  localparam int BAUD_PARITY   = 1;
  localparam int BAUD_STOP     = 2;
  localparam int FRAME_BAUDS   = BAUD_START + BAUD_DATA + BAUD_PARITY + BAUD_STOP;
  localparam int CLKS_PER_BAUD = 15259;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// rtl/uart_rx_frame_ctrl_if.sv - received-byte holding register handshake toward the packet layer
interface uart_rx_frame_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_frame_ctrl_sync.sv
// rtl/uart_rx_frame_ctrl_sync.sv - 2-FF line synchronizer with falling-edge detect
module uart_rx_sync (
  input  logic ref_clk,
  input  logic reset,
  input  logic rx_in,
  output logic rx_s,
  output logic rx_fall
);
  // Resets to the idle-high line level so leaving reset never fakes a start edge.
  logic [2:0] pipe;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      pipe <= 3'b111;
    end else begin
      pipe <= {pipe[1:0], rx_in};
    end
  end

  assign rx_s    = pipe[1];
  assign rx_fall = pipe[2] & ~pipe[1];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame sequencer with timeout and valid/ready holding register
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int DATA_BITS    = BAUD_DATA,
  parameter int STOP_BITS    = BAUD_STOP,
  parameter int PARITY_EN    = BAUD_PARITY,
  parameter int PARITY_ODD   = 0,
  parameter int TICK_TIMEOUT = 16384
) (
  input  logic ref_clk,
  input  logic reset,
  input  logic rx_in,
  input  logic baud_tick,
  output logic baud_start,
  output logic baud_abort,
  output logic rx_timeout,
  output logic busy,
  uart_rx_frame_ctrl_if.master rx_if
);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int TW = $clog2(TICK_TIMEOUT + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TICK_TIMEOUT - 1);
  localparam logic          ODD_SEL   = 1'(PARITY_ODD);

  logic                 rx_s;
  logic                 rx_fall;
  rx_state_t            state;
  logic [BW-1:0]        bit_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_flag;
  logic                 frm_flag;

  uart_rx_sync u_sync (
    .ref_clk (ref_clk),
    .reset   (reset),
    .rx_in   (rx_in),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      bit_cnt          <= '0;
      tmo_cnt          <= '0;
      shift_reg        <= '0;
      par_flag         <= 1'b0;
      frm_flag         <= 1'b0;
      baud_start       <= 1'b0;
      baud_abort       <= 1'b0;
      rx_timeout       <= 1'b0;
      busy             <= 1'b0;
      rx_if.rx_data    <= '0;
      rx_if.rx_valid   <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.overrun    <= 1'b0;
    end else begin
      baud_start <= 1'b0;
      baud_abort <= 1'b0;
      rx_timeout <= 1'b0;

      if (rx_if.rx_valid && rx_if.rx_ready) begin
        rx_if.rx_valid   <= 1'b0;
        rx_if.parity_err <= 1'b0;
        rx_if.frame_err  <= 1'b0;
        rx_if.overrun    <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state      <= ST_START;
            baud_start <= 1'b1;
            busy       <= 1'b1;
            tmo_cnt    <= '0;
            bit_cnt    <= '0;
            par_flag   <= 1'b0;
            frm_flag   <= 1'b0;
          end
        end

        ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
          // A tick in the same cycle as expiry wins: it restarts the watchdog.
          if (!baud_tick) begin
            if (tmo_cnt == TMO_LAST) begin
              rx_timeout <= 1'b1;
              baud_abort <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end else begin
            tmo_cnt <= '0;
            unique case (state)
              ST_START: begin
                if (!rx_s) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                end else begin
                  baud_abort <= 1'b1;
                  busy       <= 1'b0;
                  state      <= ST_IDLE;
                end
              end
              ST_DATA: begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                if (bit_cnt == DATA_LAST) begin
                  bit_cnt <= '0;
                  state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
              ST_PARITY: begin
                par_flag <= ((^shift_reg) ^ rx_s) != ODD_SEL;
                state    <= ST_STOP;
              end
              default: begin
                if (!rx_s) frm_flag <= 1'b1;
                if (bit_cnt == STOP_LAST) begin
                  bit_cnt <= '0;
                  state   <= ST_DONE;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
            endcase
          end
        end

        ST_DONE: begin
          // Load overrides any same-cycle accept; overrun only if the old byte is lost.
          rx_if.rx_data    <= shift_reg;
          rx_if.rx_valid   <= 1'b1;
          rx_if.parity_err <= par_flag;
          rx_if.frame_err  <= frm_flag;
          rx_if.overrun    <= rx_if.rx_valid & ~rx_if.rx_ready;
          busy             <= 1'b0;
          state            <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed table-driven bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
  logic ref_clk = 1'b0;
  logic reset   = 1'b1;
  logic rx_in   = 1'b1;
  logic baud_tick = 1'b0;
  logic baud_start, baud_abort, rx_timeout, busy;

  uart_rx_frame_ctrl_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_frame_ctrl dut (
    .ref_clk    (ref_clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .baud_tick  (baud_tick),
    .baud_start (baud_start),
    .baud_abort (baud_abort),
    .rx_timeout (rx_timeout),
    .busy       (busy),
    .rx_if      (rx_if)
  );

  always #1 ref_clk = ~ref_clk;

  int total = 0;
  int bad   = 0;
  int n_start = 0, n_abort = 0, n_tmo = 0;

  always @(negedge ref_clk) begin
    if (baud_start) n_start++;
    if (baud_abort) n_abort++;
    if (rx_timeout) n_tmo++;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       s1;
    logic       s2;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_bit(input logic v, input bit ack_done);
    @(negedge ref_clk) rx_in = v;
    repeat (5) @(negedge ref_clk);
    baud_tick = 1'b1;
    @(negedge ref_clk) baud_tick = 1'b0;
    if (ack_done) begin
      rx_ready_drive(1'b1);
      @(negedge ref_clk) rx_ready_drive(1'b0);
      repeat (4) @(negedge ref_clk);
    end else begin
      repeat (5) @(negedge ref_clk);
    end
  endtask

  task automatic rx_ready_drive(input logic v);
    rx_if.rx_ready = v;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                            input logic s2, input bit ack_done);
    tick_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick_bit(d[i], 1'b0);
    tick_bit(p, 1'b0);
    tick_bit(s1, 1'b0);
    tick_bit(s2, ack_done);
    @(negedge ref_clk) rx_in = 1'b1;
    repeat (4) @(negedge ref_clk);
  endtask

  task automatic accept();
    @(negedge ref_clk) rx_ready_drive(1'b1);
    @(negedge ref_clk) rx_ready_drive(1'b0);
  endtask

  initial begin
    int s0, a0, t0, n;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

    rx_ready_drive(1'b0);
    repeat (4) @(negedge ref_clk);
    chk("reset_valid", rx_if.rx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", rx_if.rx_data, 0);
    chk("reset_pulses", {baud_start, baud_abort, rx_timeout}, 0);
    reset = 1'b0;
    repeat (4) @(negedge ref_clk);

    for (int i = 0; i < 7; i++) begin
      s0 = n_start;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].s1, vecs[i].s2, 1'b0);
      chk($sformatf("v%0d_start_once", i), n_start - s0, 1);
      chk($sformatf("v%0d_valid", i), rx_if.rx_valid, 1);
      chk($sformatf("v%0d_data", i), rx_if.rx_data, vecs[i].exp_data);
      chk($sformatf("v%0d_perr", i), rx_if.parity_err, vecs[i].exp_perr);
      chk($sformatf("v%0d_ferr", i), rx_if.frame_err, vecs[i].exp_ferr);
      chk($sformatf("v%0d_ovr", i), rx_if.overrun, 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
      accept();
      chk($sformatf("v%0d_cleared", i),
          {rx_if.rx_valid, rx_if.parity_err, rx_if.frame_err}, 0);
    end

    // false start: 50 ns glitch
    a0 = n_abort;
    @(negedge ref_clk) rx_in = 1'b0;
    repeat (25) @(negedge ref_clk);
    rx_in = 1'b1;
    chk("glitch_busy_during", busy, 1);
    tick_bit(1'b1, 1'b0);
    chk("glitch_abort", n_abort - a0, 1);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid", rx_if.rx_valid, 0);

    // overrun then same-cycle accept+load
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovr_data", rx_if.rx_data, 8'h22);
    chk("ovr_flag", rx_if.overrun, 1);
    chk("ovr_valid", rx_if.rx_valid, 1);
    send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("acc_load_data", rx_if.rx_data, 8'h33);
    chk("acc_load_valid", rx_if.rx_valid, 1);
    chk("acc_load_ovr", rx_if.overrun, 0);
    accept();
    chk("ovr_cleared", {rx_if.rx_valid, rx_if.overrun}, 0);

    // tick timeout after 3 data bits
    a0 = n_abort; t0 = n_tmo;
    tick_bit(1'b0, 1'b0);
    tick_bit(1'b1, 1'b0);
    tick_bit(1'b0, 1'b0);
    tick_bit(1'b1, 1'b0);
    n = 5;
    while (!rx_timeout && n < 17000) begin
      @(negedge ref_clk);
      n++;
    end
    chk("tmo_cycles", n, 16384);
    @(negedge ref_clk) rx_in = 1'b1;
    chk("tmo_pulse", n_tmo - t0, 1);
    chk("tmo_abort", n_abort - a0, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_valid", rx_if.rx_valid, 0);

    // reset mid-frame
    tick_bit(1'b0, 1'b0);
    tick_bit(1'b1, 1'b0);
    chk("rst_busy_before", busy, 1);
    @(negedge ref_clk) begin rx_in = 1'b1; reset = 1'b1; end
    @(negedge ref_clk) reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", rx_if.rx_valid, 0);
    repeat (3) @(negedge ref_clk);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("post_rst_data", rx_if.rx_data, 8'h5A);
    chk("post_rst_flags", {rx_if.rx_valid, rx_if.parity_err, rx_if.frame_err, rx_if.overrun}, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
